// File: rtl/operand_collector_if.sv
// Put/seal/consume handshake plus operand slot read-out for operand_collector.
//   master: put source / downstream stage (drives put_*, seal, consume, flush)
//   slave : the collector (drives put_ready, r0..r2, count, bundle_valid, done, overflow)
interface operand_collector_if #(
    parameter int unsigned W = 8
);
    logic         put_valid;
    logic [W-1:0] put_data;
    logic         put_ready;
    logic         seal;
    logic         consume;
    logic         flush;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic [1:0]   count;
    logic         bundle_valid;
    logic         done;
    logic         overflow;

    modport master (
        output put_valid, put_data, seal, consume, flush,
        input  put_ready, r0, r1, r2, count, bundle_valid, done, overflow
    );

    modport slave (
        input  put_valid, put_data, seal, consume, flush,
        output put_ready, r0, r1, r2, count, bundle_valid, done, overflow
    );
endinterface

// File: rtl/operand_collector.sv
// Gathers up to three put immediates into slots r0..r2, then holds the bundle
// until the downstream stage consumes it.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : operand_collector_if.slave (put handshake, seal/consume/flush,
//           slot outputs, count, bundle_valid, done pulse, sticky overflow)
module operand_collector #(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             reset,
    operand_collector_if.slave bus
);
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t       state, stateNext;
    logic [1:0]   idx, idxNext;
    logic [1:0]   count, countNext;
    logic [W-1:0] slot0, slot1, slot2;
    logic [W-1:0] slot0Next, slot1Next, slot2Next;
    logic         bundleValid, bundleValidNext;
    logic         done, doneNext;
    logic         overflow, overflowNext;
    logic         accept;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            idx         <= 2'd0;
            count       <= 2'd0;
            slot0       <= '0;
            slot1       <= '0;
            slot2       <= '0;
            bundleValid <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= stateNext;
            idx         <= idxNext;
            count       <= countNext;
            slot0       <= slot0Next;
            slot1       <= slot1Next;
            slot2       <= slot2Next;
            bundleValid <= bundleValidNext;
            done        <= doneNext;
            overflow    <= overflowNext;
        end
    end

    // Next-state logic; flush overrides everything else
    always_comb begin
        stateNext       = state;
        idxNext         = idx;
        countNext       = count;
        slot0Next       = slot0;
        slot1Next       = slot1;
        slot2Next       = slot2;
        bundleValidNext = bundleValid;
        doneNext        = 1'b0;
        overflowNext    = overflow;
        accept          = 1'b0;

        if (bus.flush) begin
            stateNext       = FILL;
            idxNext         = 2'd0;
            countNext       = 2'd0;
            slot0Next       = '0;
            slot1Next       = '0;
            slot2Next       = '0;
            bundleValidNext = 1'b0;
            overflowNext    = 1'b0;
        end else begin
            case (state)
                FILL: begin
                    accept = bus.put_valid;
                    if (accept) begin
                        case (idx)
                            2'd0:    slot0Next = bus.put_data;
                            2'd1:    slot1Next = bus.put_data;
                            default: slot2Next = bus.put_data;
                        endcase
                        countNext = count + 2'd1;
                        idxNext   = (idx == 2'd2) ? idx : idx + 2'd1;
                    end
                    // Third put completes the bundle; seal closes it early.
                    // Both together still yield a single done pulse.
                    if ((accept && idx == 2'd2) || (bus.seal && (accept || count != 2'd0))) begin
                        stateNext       = HOLD;
                        bundleValidNext = 1'b1;
                        doneNext        = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.put_valid) begin
                        overflowNext = 1'b1;
                    end
                    // Slot values are kept after consume; count qualifies them
                    if (bus.consume) begin
                        stateNext       = FILL;
                        idxNext         = 2'd0;
                        countNext       = 2'd0;
                        bundleValidNext = 1'b0;
                    end
                end
                default: stateNext = FILL;
            endcase
        end
    end

    assign bus.put_ready    = (state == FILL);
    assign bus.r0           = slot0;
    assign bus.r1           = slot1;
    assign bus.r2           = slot2;
    assign bus.count        = count;
    assign bus.bundle_valid = bundleValid;
    assign bus.done         = done;
    assign bus.overflow     = overflow;
endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;
    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    operand_collector_if #(.W(W)) bus ();

    operand_collector #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.put_valid = 1'b0;
        bus.seal      = 1'b0;
        bus.consume   = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic put(input logic [W-1:0] d);
        bus.put_valid = 1'b1;
        bus.put_data  = d;
        step();
        bus.put_valid = 1'b0;
    endtask

    initial begin
        idle();
        bus.put_data = '0;
        reset = 1'b0;
        #12;
        check("rst_r0", 32'(bus.r0), 32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_bv", 32'(bus.bundle_valid), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_ovf", 32'(bus.overflow), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_ready", 32'(bus.put_ready), 32'h1);

        // Full three-operand bundle
        put(8'h12);
        check("p1_r0", 32'(bus.r0), 32'h12);
        check("p1_count", 32'(bus.count), 32'h1);
        check("p1_bv", 32'(bus.bundle_valid), 32'h0);
        put(8'h34);
        put(8'h56);
        check("p3_r0", 32'(bus.r0), 32'h12);
        check("p3_r1", 32'(bus.r1), 32'h34);
        check("p3_r2", 32'(bus.r2), 32'h56);
        check("p3_count", 32'(bus.count), 32'h3);
        check("p3_bv", 32'(bus.bundle_valid), 32'h1);
        check("p3_done", 32'(bus.done), 32'h1);
        check("p3_ready", 32'(bus.put_ready), 32'h0);
        step();
        check("p3_done_low", 32'(bus.done), 32'h0);
        check("p3_bv_hold", 32'(bus.bundle_valid), 32'h1);

        // Put while held -> overflow, data dropped
        put(8'hFF);
        check("ovf_set", 32'(bus.overflow), 32'h1);
        check("ovf_r0", 32'(bus.r0), 32'h12);
        check("ovf_r1", 32'(bus.r1), 32'h34);
        check("ovf_r2", 32'(bus.r2), 32'h56);
        check("ovf_count", 32'(bus.count), 32'h3);
        bus.consume = 1'b1;
        step();
        bus.consume = 1'b0;
        check("cons_bv", 32'(bus.bundle_valid), 32'h0);
        check("cons_ready", 32'(bus.put_ready), 32'h1);
        check("cons_count", 32'(bus.count), 32'h0);
        check("cons_ovf", 32'(bus.overflow), 32'h1);
        check("cons_r0_kept", 32'(bus.r0), 32'h12);

        // Early seal with one operand
        put(8'hA5);
        bus.seal = 1'b1;
        step();
        bus.seal = 1'b0;
        check("seal1_count", 32'(bus.count), 32'h1);
        check("seal1_r0", 32'(bus.r0), 32'hA5);
        check("seal1_r1_kept", 32'(bus.r1), 32'h34);
        check("seal1_done", 32'(bus.done), 32'h1);
        check("seal1_bv", 32'(bus.bundle_valid), 32'h1);
        step();
        check("seal1_done_low", 32'(bus.done), 32'h0);
        bus.consume = 1'b1;
        step();
        bus.consume = 1'b0;

        // Seal together with the third put: single done pulse
        put(8'h40);
        put(8'h41);
        check("sp_count2", 32'(bus.count), 32'h2);
        check("sp_done_pre", 32'(bus.done), 32'h0);
        bus.seal = 1'b1;
        put(8'h07);
        bus.seal = 1'b0;
        check("sp_r2", 32'(bus.r2), 32'h07);
        check("sp_count", 32'(bus.count), 32'h3);
        check("sp_done", 32'(bus.done), 32'h1);
        step();
        check("sp_done_once", 32'(bus.done), 32'h0);
        bus.consume = 1'b1;
        step();
        bus.consume = 1'b0;

        // Flush alongside a put
        put(8'h11);
        put(8'h22);
        bus.flush = 1'b1;
        put(8'h33);
        bus.flush = 1'b0;
        check("fl_r0", 32'(bus.r0), 32'h0);
        check("fl_r1", 32'(bus.r1), 32'h0);
        check("fl_r2", 32'(bus.r2), 32'h0);
        check("fl_count", 32'(bus.count), 32'h0);
        check("fl_ovf", 32'(bus.overflow), 32'h0);
        check("fl_ready", 32'(bus.put_ready), 32'h1);
        step();
        check("fl_no_capture", 32'(bus.r0), 32'h0);

        // Asynchronous reset mid-bundle
        put(8'h5A);
        put(8'h6B);
        check("ar_count_pre", 32'(bus.count), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("ar_count", 32'(bus.count), 32'h0);
        check("ar_r0", 32'(bus.r0), 32'h0);
        check("ar_r1", 32'(bus.r1), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        put(8'h01);
        check("ar_post_r0", 32'(bus.r0), 32'h01);
        check("ar_post_count", 32'(bus.count), 32'h1);

        // Consume in FILL is ignored; seal with consume still seals
        bus.consume = 1'b1;
        step();
        check("cf_count", 32'(bus.count), 32'h1);
        check("cf_bv", 32'(bus.bundle_valid), 32'h0);
        check("cf_ready", 32'(bus.put_ready), 32'h1);
        bus.seal = 1'b1;
        step();
        bus.seal    = 1'b0;
        bus.consume = 1'b0;
        check("cs_bv", 32'(bus.bundle_valid), 32'h1);
        check("cs_count", 32'(bus.count), 32'h1);
        check("cs_done", 32'(bus.done), 32'h1);
        check("cs_ready", 32'(bus.put_ready), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
